// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_pkg : shared funct3 codes, byte masks and FSM state encoding    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_BYTE    = 4'b0001;
  localparam logic [3:0] MASK_LO_HALF = 4'b0011;
  localparam logic [3:0] MASK_HI_HALF = 4'b1100;
  localparam logic [3:0] MASK_ALL     = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STORE_REQ = 3'd1,
    ST_LOAD_REQ  = 3'd2,
    ST_LOAD_WAIT = 3'd3,
    ST_ERR       = 3'd4
  } lsu_state_e;

  // Stores have no unsigned variants, so BU/HU are only legal for loads.
  function automatic logic f3_legal(input logic is_ld, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (is_ld && ((f3 == F3_BU) || (f3 == F3_HU))) ok = 1'b1;
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_load_align : selects the addressed lane and sign/zero-extends   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    case (i_funct3)
      F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_result = {24'h0, w_byte};
      F3_H:    o_result = {{16{w_half[15]}}, w_half};
      F3_HU:   o_result = {16'h0, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_mem_initiator : RV32I load/store initiator towards data memory  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int Address      = 8,
  parameter int CpuAddrWidth = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    is_load,
  input  logic                    is_store,
  input  logic [2:0]              funct3,
  input  logic [CpuAddrWidth-1:0] cpu_addr,
  input  logic [DataWidth-1:0]    store_data,
  output logic                    mem_request,
  output logic                    mem_we_re,
  output logic                    mem_load,
  output logic [3:0]              mem_mask,
  output logic [Address-1:0]      mem_address,
  output logic [DataWidth-1:0]    mem_data_in,
  input  logic                    mem_valid,
  input  logic [DataWidth-1:0]    mem_data_out,
  output logic                    busy,
  output logic                    done,
  output logic [DataWidth-1:0]    load_data,
  output logic                    misaligned
);

  lsu_state_e r_state;
  logic       r_req, r_we, r_ld, r_busy, r_done, r_mis;
  logic [3:0] r_mask;
  logic [Address-1:0]   r_addr;
  logic [DataWidth-1:0] r_wdata, r_ldata;
  logic [1:0] r_addr_lo;
  logic [2:0] r_f3;

  logic                 w_kind_ok, w_align_ok, w_cmd_ok;
  logic [3:0]           w_st_mask;
  logic [DataWidth-1:0] w_st_data, w_ext;
  logic [CpuAddrWidth-Address-3:0] w_unused_addr_hi;

  assign w_unused_addr_hi = cpu_addr[CpuAddrWidth-1:Address+2];

  always_comb begin
    w_kind_ok = (is_load ^ is_store) && f3_legal(is_load, funct3);
    case (funct3[1:0])
      2'b00:   w_align_ok = 1'b1;
      2'b01:   w_align_ok = ~cpu_addr[0];
      2'b10:   w_align_ok = (cpu_addr[1:0] == 2'b00);
      default: w_align_ok = 1'b0;
    endcase
    w_cmd_ok = w_kind_ok && w_align_ok;

    // Data is replicated across every lane so the responder only needs the mask.
    case (funct3[1:0])
      2'b00: begin
        w_st_mask = MASK_BYTE << cpu_addr[1:0];
        w_st_data = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_st_mask = cpu_addr[1] ? MASK_HI_HALF : MASK_LO_HALF;
        w_st_data = {2{store_data[15:0]}};
      end
      default: begin
        w_st_mask = MASK_ALL;
        w_st_data = store_data;
      end
    endcase
  end

  lsu_load_align u_align (
    .i_word   (mem_data_out),
    .i_addr   (r_addr_lo),
    .i_funct3 (r_f3),
    .o_result (w_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_ld      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mis     <= 1'b0;
      r_mask    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ldata   <= '0;
      r_addr_lo <= '0;
      r_f3      <= '0;
    end else begin
      r_req  <= 1'b0;
      r_ld   <= 1'b0;
      r_done <= 1'b0;
      r_mis  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_cmd_ok) begin
              r_addr_lo <= cpu_addr[1:0];
              r_f3      <= funct3;
              r_addr    <= cpu_addr[Address+1:2];
              r_req     <= 1'b1;
              r_busy    <= 1'b1;
              if (is_store) begin
                r_we    <= 1'b1;
                r_mask  <= w_st_mask;
                r_wdata <= w_st_data;
                r_state <= ST_STORE_REQ;
              end else begin
                r_we    <= 1'b0;
                r_ld    <= 1'b1;
                r_mask  <= MASK_ALL;
                r_state <= ST_LOAD_REQ;
              end
            end else begin
              r_done  <= 1'b1;
              r_mis   <= 1'b1;
              r_state <= ST_ERR;
            end
          end
        end
        ST_STORE_REQ: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_LOAD_REQ: r_state <= ST_LOAD_WAIT;
        ST_LOAD_WAIT: begin
          if (mem_valid) begin
            r_ldata <= w_ext;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_request = r_req;
  assign mem_we_re   = r_we;
  assign mem_load    = r_ld;
  assign mem_mask    = r_mask;
  assign mem_address = r_addr;
  assign mem_data_in = r_wdata;
  assign busy        = r_busy;
  assign done        = r_done;
  assign load_data   = r_ldata;
  assign misaligned  = r_mis;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lsu_mem_initiator : scoreboard bench with memory responder model |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] cpu_addr = 32'h0, store_data = 32'h0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data_out = 32'h0;
  logic        mem_request, mem_we_re, mem_load, busy, done, misaligned;
  logic [3:0]  mem_mask;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in, load_data;

  lsu_mem_initiator dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .cpu_addr(cpu_addr), .store_data(store_data),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_load(mem_load),
    .mem_mask(mem_mask), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_valid(mem_valid), .mem_data_out(mem_data_out), .busy(busy), .done(done),
    .load_data(load_data), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; bit [3:0] mask; bit [7:0] addr; bit [31:0] data; } req_t;
  typedef struct { bit mis; bit [31:0] ld; } res_t;

  req_t exp_req[$];
  res_t exp_res[$];
  bit [7:0]  ref_mem [0:1023];
  bit [7:0]  rsp_mem [0:1023];
  bit [31:0] last_ld = 32'h0;
  int        tests = 0, fails = 0;
  int        rsp_extra = 0, rsp_wait = 0;
  bit        rsp_noise = 1'b0;
  bit [7:0]  rsp_word = 8'h0;

  task automatic check(input string name, input bit [63:0] act, input bit [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: read data returns rsp_extra+1 cycles after the request.
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (rsp_wait > 0) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        mem_valid = 1'b1;
        mem_data_out = {rsp_mem[{rsp_word, 2'd3}], rsp_mem[{rsp_word, 2'd2}],
                        rsp_mem[{rsp_word, 2'd1}], rsp_mem[{rsp_word, 2'd0}]};
      end
    end
    if (rst && mem_request) begin
      if (mem_we_re) begin
        for (int k = 0; k < 4; k++)
          if (mem_mask[k]) rsp_mem[{mem_address, k[1:0]}] = mem_data_in[8*k +: 8];
      end else begin
        rsp_wait = rsp_extra + 1;
        rsp_word = mem_address;
      end
    end else if (rsp_noise && !mem_valid && rsp_wait == 0 && $urandom_range(0, 3) == 0) begin
      mem_valid = 1'b1;
      mem_data_out = 32'hBAD0BAD0;
    end
  end

  // Monitor: every request and every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_request) begin
        if (exp_req.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_request: got addr %0h expected none", mem_address);
        end else begin
          req_t r;
          r = exp_req.pop_front();
          check("request", {mem_we_re, mem_load, mem_mask, mem_address, mem_we_re ? mem_data_in : 32'h0},
                {r.we, ~r.we, r.mask, r.addr, r.data});
        end
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          res_t e;
          e = exp_res.pop_front();
          check("completion", {misaligned, busy, load_data}, {e.mis, 1'b0, e.ld});
        end
      end
      if (misaligned && !done) check("misaligned_without_done", 1, 0);
    end
  end

  task automatic do_cmd(input bit ld, input bit st, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wd, input int extra, input bit poke);
    int size, explat, lat;
    bit ok, busy_ok;
    bit [3:0] mask;
    bit [31:0] data, val;
    size = 1 << f3[1:0];
    ok = (ld ^ st) && (ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2}))
         && (addr % size == 0);
    if (!ok) begin
      exp_res.push_back('{1'b1, last_ld});
      explat = 1;
    end else if (st) begin
      mask = 4'h0;
      for (int k = 0; k < 4; k++) data[8*k +: 8] = wd[8*(k % size) +: 8];
      for (int i = 0; i < size; i++) begin
        mask[addr[1:0] + i] = 1'b1;
        ref_mem[addr[9:0] + i] = wd[8*i +: 8];
      end
      exp_req.push_back('{1'b1, mask, addr[9:2], data});
      exp_res.push_back('{1'b0, last_ld});
      explat = 2;
    end else begin
      val = 32'h0;
      for (int i = 0; i < size; i++) val[8*i +: 8] = ref_mem[addr[9:0] + i];
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
      last_ld = val;
      exp_req.push_back('{1'b0, 4'hF, addr[9:2], 32'h0});
      exp_res.push_back('{1'b0, val});
      explat = 3 + extra;
    end
    rsp_extra = extra;
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; cpu_addr = addr; store_data = wd;
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (poke && lat == 3) begin
        start = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010;
      end
      if (poke && lat == 4) start = 1'b0;
      if (!done && (ok != busy)) busy_ok = 1'b0;
    end while (!done && lat < 60);
    check("latency", lat, explat);
    check("busy_window", busy_ok, 1);
    @(negedge clk);
  endtask

  typedef struct { bit [2:0] f3; bit [31:0] addr; bit [31:0] val; } ld_vec_t;
  ld_vec_t lvec[6];

  initial begin
    bit [7:0] b;
    bit [2:0] f3;
    bit [31:0] addr;
    bit ld, st, saw_done;
    int r, size;
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      ref_mem[i] = b;
      rsp_mem[i] = b;
    end
    ref_mem[20] = 8'h01; ref_mem[21] = 8'h7F; ref_mem[22] = 8'hFF; ref_mem[23] = 8'h80;
    rsp_mem[20] = 8'h01; rsp_mem[21] = 8'h7F; rsp_mem[22] = 8'hFF; rsp_mem[23] = 8'h80;

    repeat (3) @(negedge clk);
    check("reset_ctrl", {mem_request, mem_we_re, mem_load, mem_mask, mem_address, busy, done, misaligned}, 0);
    check("reset_data", {mem_data_in, load_data}, 0);
    rst = 1'b1;
    @(negedge clk);

    do_cmd(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0);
    do_cmd(0, 1, 3'b000, 32'h13, 32'h000000A5, 0, 0);
    check("sb_data", mem_data_in, 32'hA5A5A5A5);
    do_cmd(0, 1, 3'b001, 32'h12, 32'h00001234, 0, 0);
    check("sh_mask", mem_mask, 4'b1100);

    lvec[0] = '{3'b000, 32'h15, 32'h0000007F};
    lvec[1] = '{3'b000, 32'h16, 32'hFFFFFFFF};
    lvec[2] = '{3'b100, 32'h16, 32'h000000FF};
    lvec[3] = '{3'b001, 32'h16, 32'hFFFF80FF};
    lvec[4] = '{3'b101, 32'h16, 32'h000080FF};
    lvec[5] = '{3'b010, 32'h14, 32'h80FF7F01};
    foreach (lvec[i]) begin
      do_cmd(1, 0, lvec[i].f3, lvec[i].addr, 32'h0, 0, 0);
      check("load_value", load_data, lvec[i].val);
    end

    do_cmd(1, 0, 3'b010, 32'h02, 32'h0, 0, 0);
    do_cmd(0, 1, 3'b001, 32'h01, 32'h0, 0, 0);
    do_cmd(1, 0, 3'b011, 32'h14, 32'h0, 0, 0);
    do_cmd(0, 1, 3'b100, 32'h14, 32'h0, 0, 0);
    do_cmd(1, 1, 3'b010, 32'h14, 32'h0, 0, 0);
    do_cmd(0, 0, 3'b010, 32'h14, 32'h0, 0, 0);

    do_cmd(1, 0, 3'b000, 32'h17, 32'h0, 4, 1);

    // Abort a load in flight; the late read data must not complete anything.
    exp_req.push_back('{1'b0, 4'hF, 8'h05, 32'h0});
    rsp_extra = 10;
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; cpu_addr = 32'h14;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_ctrl", {mem_request, mem_we_re, mem_load, mem_mask, mem_address, busy, done, misaligned}, 0);
    check("abort_data", {mem_data_in, load_data}, 0);
    last_ld = 32'h0;
    exp_res.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_abort", saw_done, 0);
    do_cmd(0, 1, 3'b010, 32'h20, 32'h0BADF00D, 0, 0);
    do_cmd(1, 0, 3'b010, 32'h20, 32'h0, 0, 0);

    rsp_noise = 1'b1;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      ld = (r < 4) || (r == 8);
      st = (r >= 4 && r < 8) || (r == 8);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      size = 1 << f3[1:0];
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(size) - 32'd1);
      do_cmd(ld, st, f3, addr, $urandom, $urandom_range(0, 3), 0);
    end
    rsp_noise = 1'b0;
    repeat (4) @(negedge clk);
    check("queues_drained", {32'(exp_req.size()), 32'(exp_res.size())}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
Load/store initiator for the RV32I data path. It accepts one load or store command from the execute stage. It validates alignment, builds the byte mask and lane-replicated write data, and drives a single request to the data-memory responder. For loads it waits for the responder's valid, then extracts and sign/zero-extends the result. It stalls the pipeline via busy and reports completion or misalignment.

Parameters:
DataWidth, 32, memory data width (only 32 supported)
Address, 8, word-address width of data memory
CpuAddrWidth, 32, byte-address width from execute stage

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
start  input  1  command strobe from execute stage
is_load  input  1  command is a load
is_store  input  1  command is a store
funct3  input  3  RV32I width/sign code (LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010)
cpu_addr  input  CpuAddrWidth  effective byte address
store_data  input  32  rs2 value
mem_request  output  1  request strobe to memory
mem_we_re  output  1  1=write, 0=read
mem_load  output  1  load marker (responder returns valid one cycle later)
mem_mask  output  4  byte-lane write mask
mem_address  output  Address  word address = cpu_addr[Address+1:2]
mem_data_in  output  32  lane-replicated write data
mem_valid  input  1  read data valid from responder
mem_data_out  input  32  read word from responder
busy  output  1  command in flight; pipeline must stall
done  output  1  one-cycle completion pulse
load_data  output  32  extended load result, held until next load completes
misaligned  output  1  one-cycle pulse with done on alignment or illegal-code error

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-operation aborts the command with no done pulse and drops mem_request immediately.
- All outputs are registered.
- States: IDLE, STORE_REQ, LOAD_REQ, LOAD_WAIT, ERR.
- IDLE, start=1, exactly one of is_load/is_store set, legal funct3, aligned:
  - Latch cpu_addr, funct3 and store_data.
  - Go to STORE_REQ or LOAD_REQ. busy=1 from the next cycle.
- Error conditions:
  - is_load and is_store both set, neither set, or illegal funct3 → ERR.
  - LH/LHU/SH with addr[0]=1 → ERR.
  - LW/SW with addr[1:0]≠0 → ERR.
- ERR: one cycle with done=1, misaligned=1, busy=0, no memory request. Then IDLE.
- STORE_REQ: one cycle with mem_request=1, mem_we_re=1, mem_load=0, mask/data per rules below. Next cycle done=1, then IDLE. Latency from start to done: 2 cycles.
- LOAD_REQ: one cycle with mem_request=1, mem_we_re=0, mem_load=1, mem_mask=4'b1111. Then LOAD_WAIT.
- LOAD_WAIT: stay until mem_valid=1. On that cycle, capture mem_data_out, extract and extend. Next cycle done=1, load_data updated, then IDLE. Nominal latency from start to done: 3 cycles. No timeout.
- busy is 1 in STORE_REQ, LOAD_REQ and LOAD_WAIT only. It drops in the same cycle that done is asserted.
- start while busy=1 is ignored. The execute stage must hold the command until done.
- A mem_valid received in IDLE or a store state is ignored.
- Store mask/data:
  - SB: mask = 1<<addr[1:0]; data = {4{rs2[7:0]}}.
  - SH: mask = addr[1] ? 1100 : 0011; data = {2{rs2[15:0]}}.
  - SW: mask = 1111; data = rs2.
- Load extraction:
  - Byte lane = addr[1:0]; halfword = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- mem_address, mem_mask and mem_data_in hold their value outside request cycles. The responder qualifies them only with mem_request.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum typedef lsu_state_e.
  - MASK_* constants.
- One combinational sub-module lsu_load_align (inputs: word, addr[1:0], funct3; output: extended 32-bit). Reusable by the bench's reference model.

Test Plan:
- SW addr 0x0000_0010, rs2 0xDEADBEEF → request at t+1 with we_re=1, mask 1111, mem_address 0x04, data 0xDEADBEEF; done at t+2; busy high only at t+1.
- SB addr 0x13, rs2 0x0000_00A5 → mask 1000, data 0xA5A5A5A5; SH addr 0x12, rs2 0x1234 → mask 1100, data 0x12341234.
- Memory word 0x80FF7F01 at word 0x05. Loads at byte 0x14..0x17:
  - LB 0x15 → 0x0000007F; LB 0x16 → 0xFFFFFFFF; LBU 0x16 → 0x000000FF.
  - LH 0x16 → 0xFFFF80FF; LHU 0x16 → 0x000080FF; LW 0x14 → 0x80FF7F01.
  - Each load: done at t+3.
- LW addr 0x02, SH addr 0x01, and funct3=011 → done+misaligned at t+1; mem_request never asserted.
- Responder delays mem_valid by 4 extra cycles → busy held, no second request, done exactly one cycle after valid. A start pulse during the wait is ignored.
- Assert rst during LOAD_WAIT → all outputs 0 immediately. A late mem_valid produces no done. The next SW completes normally.
